// File: rtl/issue_ctrl_pkg.sv
// Shared definitions for the issue controller: slot state encodings,
// default load/store outstanding limit, slot record and a saturating helper.
package issue_ctrl_pkg;

    // Slot state encodings
    localparam logic [0:0] ISSUE_EMPTY = 1'b0;
    localparam logic [0:0] ISSUE_PEND  = 1'b1;

    // Default maximum number of outstanding load/store instructions
    localparam int LS_MAX_DEFAULT = 2;

    // Decoded instruction held in the issue slot
    typedef struct packed {
        logic [5:0]  op;
        logic        rs1_v;
        logic [4:0]  rs1;
        logic        rs2_v;
        logic [4:0]  rs2;
        logic        rd_v;
        logic [4:0]  rd;
        logic        imm_v;
        logic [31:0] imm;
        logic        ls;
    } slot_t;

    // 32-bit increment that sticks at all-ones
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// Register scoreboard: one busy bit per architectural register (x0 never busy).
// A set and a clear of the same register on one edge leaves it busy.
// Queries are bypassed: a register being cleared this cycle reads as free.
module issue_ctrl_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_v_i,
    input  logic [4:0]  set_rd_i,
    input  logic        clr_v_i,
    input  logic [4:0]  clr_rd_i,
    input  logic [4:0]  q1_rd_i,
    input  logic [4:0]  q2_rd_i,
    input  logic [4:0]  q3_rd_i,
    output logic        q1_busy_o,
    output logic        q2_busy_o,
    output logic        q3_busy_o,
    output logic [31:0] busy_o
);

    logic [31:0] busy_q, busy_d;

    // Next busy vector: clear first so a simultaneous set wins
    always_comb begin
        busy_d = busy_q;
        if (clr_v_i)
            busy_d[clr_rd_i] = 1'b0;
        if (set_v_i && set_rd_i != 5'd0)
            busy_d[set_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // Busy vector register
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign q1_busy_o = (q1_rd_i != 5'd0) && busy_q[q1_rd_i] && !(clr_v_i && clr_rd_i == q1_rd_i);
    assign q2_busy_o = (q2_rd_i != 5'd0) && busy_q[q2_rd_i] && !(clr_v_i && clr_rd_i == q2_rd_i);
    assign q3_busy_o = (q3_rd_i != 5'd0) && busy_q[q3_rd_i] && !(clr_v_i && clr_rd_i == q3_rd_i);
    assign busy_o    = busy_q;

endmodule

// File: rtl/issue_ctrl.sv
// Decode-to-execute issue controller: single instruction slot, RAW/WAW
// hazard check against a register scoreboard, load/store outstanding limit.
// Optional feature: define ISSUE_STALL_CNT_EN to add the stall_cycles counter.
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int LS_MAX = LS_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  dec_op,
    input  logic        dec_rs1_v,
    input  logic [4:0]  dec_rs1,
    input  logic        dec_rs2_v,
    input  logic [4:0]  dec_rs2,
    input  logic        dec_rd_v,
    input  logic [4:0]  dec_rd,
    input  logic        dec_imm_v,
    input  logic [31:0] dec_imm,
    input  logic        dec_ls,
    output logic        iss_valid,
    input  logic        iss_ready,
    output logic [5:0]  iss_op,
    output logic [4:0]  iss_rs1,
    output logic [4:0]  iss_rs2,
    output logic [4:0]  iss_rd,
    output logic        iss_imm_v,
    output logic [31:0] iss_imm,
    output logic        iss_ls,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        ls_done,
    input  logic        flush,
    output logic [31:0] busy_mask
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic [0:0] state_q, state_d;
    slot_t      slot_q, slot_d;
    logic [2:0] ls_cnt_q, ls_cnt_d;
    logic       fire, accept, stall, ls_full;
    logic       rs1_busy, rs2_busy, rd_busy;
    logic       ls_inc, ls_dec;

    issue_ctrl_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_v_i   (fire && slot_q.rd_v),
        .set_rd_i  (slot_q.rd),
        .clr_v_i   (wb_valid),
        .clr_rd_i  (wb_rd),
        .q1_rd_i   (slot_q.rs1),
        .q2_rd_i   (slot_q.rs2),
        .q3_rd_i   (slot_q.rd),
        .q1_busy_o (rs1_busy),
        .q2_busy_o (rs2_busy),
        .q3_busy_o (rd_busy),
        .busy_o    (busy_mask)
    );

    // A completing load/store this cycle frees a slot in the limit check
    assign ls_full   = slot_q.ls && (ls_cnt_q == 3'(LS_MAX)) && !ls_done;
    assign stall     = (slot_q.rs1_v && rs1_busy) || (slot_q.rs2_v && rs2_busy) ||
                       (slot_q.rd_v && rd_busy) || ls_full;
    assign iss_valid = (state_q == ISSUE_PEND) && !stall && !flush;
    assign fire      = iss_valid && iss_ready;
    assign in_ready  = !rst && !flush && ((state_q == ISSUE_EMPTY) || fire);
    assign accept    = in_valid && in_ready;

    // Slot state and contents; a new accept refills the slot on the issue edge
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (flush)
            state_d = ISSUE_EMPTY;
        else if (accept)
            state_d = ISSUE_PEND;
        else if (fire)
            state_d = ISSUE_EMPTY;
        if (accept) begin
            slot_d.op    = dec_op;
            slot_d.rs1_v = dec_rs1_v;
            slot_d.rs1   = dec_rs1;
            slot_d.rs2_v = dec_rs2_v;
            slot_d.rs2   = dec_rs2;
            slot_d.rd_v  = dec_rd_v;
            slot_d.rd    = dec_rd;
            slot_d.imm_v = dec_imm_v;
            slot_d.imm   = dec_imm;
            slot_d.ls    = dec_ls;
        end
    end

    // Outstanding load/store count; done at zero is dropped
    always_comb begin
        ls_inc   = fire && slot_q.ls;
        ls_dec   = ls_done && (ls_cnt_q != 3'd0);
        ls_cnt_d = ls_cnt_q;
        if (ls_inc && !ls_dec)
            ls_cnt_d = ls_cnt_q + 3'd1;
        else if (ls_dec && !ls_inc)
            ls_cnt_d = ls_cnt_q - 3'd1;
    end

    // Slot and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ISSUE_EMPTY;
            slot_q   <= '0;
            ls_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            ls_cnt_q <= ls_cnt_d;
        end
    end

    assign iss_op    = slot_q.op;
    assign iss_rs1   = slot_q.rs1;
    assign iss_rs2   = slot_q.rs2;
    assign iss_rd    = slot_q.rd;
    assign iss_imm_v = slot_q.imm_v;
    assign iss_imm   = slot_q.imm;
    assign iss_ls    = slot_q.ls;

`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles a pending instruction is held back by a hazard
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt_q <= '0;
        else if (state_q == ISSUE_PEND && stall && !flush)
            stall_cnt_q <= sat_inc32(stall_cnt_q);
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl (LS_MAX = 2).
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  dec_op;
    logic        dec_rs1_v;
    logic [4:0]  dec_rs1;
    logic        dec_rs2_v;
    logic [4:0]  dec_rs2;
    logic        dec_rd_v;
    logic [4:0]  dec_rd;
    logic        dec_imm_v;
    logic [31:0] dec_imm;
    logic        dec_ls;
    logic        iss_valid;
    logic        iss_ready;
    logic [5:0]  iss_op;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        iss_imm_v;
    logic [31:0] iss_imm;
    logic        iss_ls;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ls_done;
    logic        flush;
    logic [31:0] busy_mask;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [5:0] OP_ADDI = 6'h13;
    localparam logic [5:0] OP_LD   = 6'h03;

    issue_ctrl #(.LS_MAX(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dec_op(dec_op), .dec_rs1_v(dec_rs1_v), .dec_rs1(dec_rs1),
        .dec_rs2_v(dec_rs2_v), .dec_rs2(dec_rs2),
        .dec_rd_v(dec_rd_v), .dec_rd(dec_rd),
        .dec_imm_v(dec_imm_v), .dec_imm(dec_imm), .dec_ls(dec_ls),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_imm_v(iss_imm_v), .iss_imm(iss_imm), .iss_ls(iss_ls),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .ls_done(ls_done), .flush(flush),
        .busy_mask(busy_mask)
`ifdef ISSUE_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] op, input logic rs1_v, input logic [4:0] rs1,
                         input logic rs2_v, input logic [4:0] rs2,
                         input logic rd_v, input logic [4:0] rd,
                         input logic [31:0] imm, input logic ls);
        in_valid  = 1'b1;
        dec_op    = op;
        dec_rs1_v = rs1_v;  dec_rs1 = rs1;
        dec_rs2_v = rs2_v;  dec_rs2 = rs2;
        dec_rd_v  = rd_v;   dec_rd  = rd;
        dec_imm_v = 1'b1;   dec_imm = imm;
        dec_ls    = ls;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; iss_ready = 1'b1;
        dec_op = '0; dec_rs1_v = 0; dec_rs1 = 0; dec_rs2_v = 0; dec_rs2 = 0;
        dec_rd_v = 0; dec_rd = 0; dec_imm_v = 0; dec_imm = 0; dec_ls = 0;
        wb_valid = 0; wb_rd = 0; ls_done = 0; flush = 0;

        // ---- reset state
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_iss_valid", iss_valid, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_iss_imm", iss_imm, 0);
        rst = 1'b0; #1;
        chk("post_rst_in_ready", in_ready, 1);

        // ---- back-to-back independent ADDI x1,x0,5 ; ADDI x2,x0,7
        offer(OP_ADDI, 1, 0, 0, 0, 1, 1, 5, 0); #1;
        chk("b2b_first_no_issue", iss_valid, 0);
        tick();
        offer(OP_ADDI, 1, 0, 0, 0, 1, 2, 7, 0); #1;
        chk("b2b_x1_valid", iss_valid, 1);
        chk("b2b_x1_rd", iss_rd, 1);
        chk("b2b_x1_imm", iss_imm, 5);
        chk("b2b_in_ready_on_fire", in_ready, 1);
        tick();
        in_valid = 0; #1;
        chk("b2b_x2_valid", iss_valid, 1);
        chk("b2b_x2_rd", iss_rd, 2);
        chk("b2b_busy_x1", busy_mask, 32'h2);
        tick();
        chk("b2b_busy", busy_mask, 32'h6);
        chk("b2b_empty", iss_valid, 0);

        // ---- WAW on x1 resolved by same-cycle write-back; set wins
        offer(OP_ADDI, 1, 0, 0, 0, 1, 1, 3, 0);
        tick();
        in_valid = 0; #1;
        chk("waw_stall", iss_valid, 0);
        wb_valid = 1; wb_rd = 1; #1;
        chk("waw_bypass", iss_valid, 1);
        tick();
        wb_valid = 0; #1;
        chk("set_wins", busy_mask, 32'h6);
        wb_valid = 1; wb_rd = 1; tick();
        wb_rd = 2; tick();
        wb_valid = 0; #1;
        chk("clear_all", busy_mask, 0);

        // ---- RAW: ADDI x3 ; ADDI x4,x3,1
        offer(OP_ADDI, 1, 0, 0, 0, 1, 3, 1, 0);
        tick();
        offer(OP_ADDI, 1, 3, 0, 0, 1, 4, 1, 0); #1;
        chk("raw_x3_issue", iss_valid, 1);
        tick();
        in_valid = 0; #1;
        chk("raw_stall", iss_valid, 0);
        chk("raw_in_ready", in_ready, 0);
        chk("raw_busy3", busy_mask, 32'h8);
        tick();
        chk("raw_still_stall", iss_valid, 0);
        wb_valid = 1; wb_rd = 3; #1;
        chk("raw_bypass_issue", iss_valid, 1);
        tick();
        wb_valid = 0; #1;
        chk("raw_busy4", busy_mask, 32'h10);
        chk("raw_empty", iss_valid, 0);

        // ---- x0 handling
        offer(OP_ADDI, 1, 0, 0, 0, 1, 0, 1, 0);
        tick();
        in_valid = 0; #1;
        chk("x0_issue", iss_valid, 1);
        tick();
        chk("x0_busy", busy_mask, 32'h10);
        offer(OP_ADDI, 1, 0, 1, 0, 1, 0, 2, 0);
        wb_valid = 1; wb_rd = 0;
        tick();
        in_valid = 0; wb_valid = 0; #1;
        chk("x0_no_stall", iss_valid, 1);
        tick();
        chk("x0_busy_after", busy_mask, 32'h10);

        // ---- load/store limit
        offer(OP_LD, 1, 0, 0, 0, 0, 0, 0, 1);
        tick();                                  // L1 pending
        #1; chk("ls_l1", iss_valid, 1);
        tick();                                  // L1 fires (cnt 1), L2 pending
        #1; chk("ls_l2", iss_valid, 1);
        tick();                                  // L2 fires (cnt 2), L3 pending
        in_valid = 0; #1;
        chk("ls_l3_stall", iss_valid, 0);
        chk("ls_l3_iss_ls", iss_ls, 1);
        tick();
        chk("ls_l3_still_stall", iss_valid, 0);
        ls_done = 1;
        offer(OP_LD, 1, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("ls_l3_done_bypass", iss_valid, 1);
        tick();                                  // L3 fires with done, cnt 2; L4 pending
        ls_done = 0; in_valid = 0; #1;
        chk("ls_cnt_held", iss_valid, 0);
        ls_done = 1; #1;
        chk("ls_l4_done_bypass", iss_valid, 1);
        tick();                                  // L4 fires, cnt 2
        tick(); tick();                          // cnt 1, 0
        tick();                                  // done at zero, ignored
        ls_done = 0;
        offer(OP_LD, 1, 0, 0, 0, 0, 0, 0, 1);
        tick();
        #1; chk("ls_l5", iss_valid, 1);
        tick();
        #1; chk("ls_l6", iss_valid, 1);
        tick();
        in_valid = 0; #1;
        chk("ls_no_underflow", iss_valid, 0);
        flush = 1; tick();
        flush = 0; ls_done = 1; tick(); tick();
        ls_done = 0;

        // ---- backpressure then flush
        iss_ready = 0;
        offer(OP_ADDI, 1, 0, 0, 0, 1, 5, 9, 0);
        tick();
        offer(OP_ADDI, 1, 0, 0, 0, 1, 6, 1, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_valid", iss_valid, 1);
            chk("bp_rd", iss_rd, 5);
            chk("bp_imm", iss_imm, 9);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        flush = 1; #1;
        chk("flush_no_issue", iss_valid, 0);
        chk("flush_in_ready", in_ready, 0);
        tick();
        flush = 0; in_valid = 0; #1;
        chk("flush_empty", iss_valid, 0);
        chk("flush_in_ready_after", in_ready, 1);
        chk("flush_busy", busy_mask, 32'h10);
        iss_ready = 1;

        // ---- reset mid-operation
        offer(OP_ADDI, 1, 4, 0, 0, 1, 6, 1, 0);
        tick();
        in_valid = 0; #1;
        chk("pre_rst_stall", iss_valid, 0);
        rst = 1; tick();
        chk("mid_rst_valid", iss_valid, 0);
        chk("mid_rst_busy", busy_mask, 0);
        chk("mid_rst_rd", iss_rd, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        rst = 0; #1;
        chk("after_rst_in_ready", in_ready, 1);
        chk("after_rst_valid", iss_valid, 0);
`ifdef ISSUE_STALL_CNT_EN
        chk("after_rst_stall_cnt", stall_cycles, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
